// File: rtl/ifetch.sv
// Instruction fetch stage: one-outstanding imem requests, registered IF/ID slot plus a one-entry skid buffer.
// Optional IFETCH_ALIGN_CHK_EN: flags misaligned redirect targets on o_misaligned and word-aligns the target.
module ifetch #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic        o_pc_write,
  output logic [31:0] o_next_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_if_valid,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_instr,
  input  logic        i_id_ready
`ifdef IFETCH_ALIGN_CHK_EN
  ,
  output logic        o_misaligned
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_pc_q;
  logic [31:0] skid_pc_q, skid_instr_q;
  logic [31:0] redirect_tgt;
  logic        slot_free;
  logic        latch_req, load_out, out_from_skid, load_skid;

`ifdef IFETCH_ALIGN_CHK_EN
  assign redirect_tgt = {i_redirect_pc[31:2], 2'b00};
  assign o_misaligned = !i_rst && i_redirect && (i_redirect_pc[1:0] != 2'b00);
`else
  assign redirect_tgt = i_redirect_pc;
`endif

  assign o_imem_req_addr = i_pc;
  assign slot_free       = !o_if_valid || i_id_ready;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d          = state_q;
    o_pc_write       = 1'b0;
    o_next_pc        = i_pc + 32'd4;
    o_imem_req_valid = 1'b0;
    latch_req        = 1'b0;
    load_out         = 1'b0;
    out_from_skid    = 1'b0;
    load_skid        = 1'b0;
    if (!i_rst) begin
      o_imem_req_valid = (state_q == REQ) && !i_redirect;
      if (i_redirect) begin
        o_pc_write = 1'b1;
        o_next_pc  = redirect_tgt;
        // An in-flight request must have its response thrown away unless it lands right now.
        case (state_q)
          WAIT, DROP: state_d = i_imem_rsp_valid ? REQ : DROP;
          default:    state_d = REQ;
        endcase
      end else begin
        case (state_q)
          IDLE: state_d = REQ;
          REQ: if (i_imem_req_ready) begin
            o_pc_write = 1'b1;
            latch_req  = 1'b1;
            state_d    = WAIT;
          end
          WAIT: if (i_imem_rsp_valid) begin
            if (slot_free) begin
              load_out = 1'b1;
              state_d  = REQ;
            end else begin
              load_skid = 1'b1;
              state_d   = HOLD;
            end
          end
          HOLD: if (i_id_ready) begin
            load_out      = 1'b1;
            out_from_skid = 1'b1;
            state_d       = REQ;
          end
          DROP: if (i_imem_rsp_valid) state_d = REQ;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  // The skid buffer is "full" exactly when state_q == HOLD, so resetting the state empties it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      o_if_valid <= 1'b0;
      o_if_pc    <= 32'd0;
      o_if_instr <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      if (i_redirect) begin
        o_if_valid <= 1'b0;
        o_if_instr <= NOP_INSTR;
      end else if (load_out) begin
        o_if_valid <= 1'b1;
        o_if_pc    <= out_from_skid ? skid_pc_q    : req_pc_q;
        o_if_instr <= out_from_skid ? skid_instr_q : i_imem_rsp_data;
      end else if (o_if_valid && i_id_ready) begin
        o_if_valid <= 1'b0;
        o_if_instr <= NOP_INSTR;
      end
    end
  end

  // NOTE: pure data-path registers carry no reset; they are only read while the FSM marks them valid.
  always_ff @(posedge i_clk) begin
    if (latch_req) req_pc_q <= i_pc;
    if (load_skid) begin
      skid_pc_q    <= req_pc_q;
      skid_instr_q <= i_imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios then random traffic, compared against a
// transaction-level model (PC register, single-outstanding memory, queue of deliverable fetches).
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc;
  logic        o_pc_write;
  logic [31:0] o_next_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid;
  logic [31:0] i_imem_rsp_data;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        i_id_ready;
`ifdef IFETCH_ALIGN_CHK_EN
  logic        o_misaligned;
`endif

  ifetch #(.NOP_INSTR(NOP)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_pc             (i_pc),
    .o_pc_write       (o_pc_write),
    .o_next_pc        (o_next_pc),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_if_valid       (o_if_valid),
    .o_if_pc          (o_if_pc),
    .o_if_instr       (o_if_instr),
    .i_id_ready       (i_id_ready)
`ifdef IFETCH_ALIGN_CHK_EN
    ,
    .o_misaligned     (o_misaligned)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  int          total = 0;
  int          bad   = 0;
  fetch_t      outq[$];      // fetches delivered to the IF/ID side but not yet consumed
  logic [31:0] pc_m;         // the PC register
  logic [31:0] pend_addr;    // address of the outstanding memory request
  logic [31:0] salt;
  bit          outstanding, killed, first;
  int          lat_cnt, lat_cfg;
  bit          lat_rand;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model past the rising edge.
  task automatic step(input bit rd, input logic [31:0] rd_pc, input bit rq_rdy, input bit id_rdy);
    bit          rsp, exp_req, hs, consume, exp_pw;
    logic [31:0] exp_npc, tgt, rdata;
    rsp   = outstanding && (lat_cnt == 1);
    rdata = rsp ? mem_fn(pend_addr) : $urandom;
    i_redirect       = rd;
    i_redirect_pc    = rd_pc;
    i_imem_req_ready = rq_rdy;
    i_id_ready       = id_rdy;
    i_pc             = pc_m;
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data  = rdata;
`ifdef IFETCH_ALIGN_CHK_EN
    tgt = {rd_pc[31:2], 2'b00};
`else
    tgt = rd_pc;
`endif
    exp_req = !first && !rd && !outstanding && (outq.size() < 2);
    hs      = exp_req && rq_rdy;
    consume = (outq.size() != 0) && id_rdy;
    exp_pw  = rd || hs;
    exp_npc = rd ? tgt : pc_m + 32'd4;

    @(negedge i_clk);
    chk("if_valid", o_if_valid, outq.size() != 0);
    if (outq.size() != 0) begin
      chk("if_pc", o_if_pc, outq[0].pc);
      chk("if_instr", o_if_instr, outq[0].instr);
    end else begin
      chk("if_instr_nop", o_if_instr, NOP);
    end
    chk("req_valid", o_imem_req_valid, exp_req);
    chk("req_addr", o_imem_req_addr, pc_m);
    chk("pc_write", o_pc_write, exp_pw);
    if (exp_pw) chk("next_pc", o_next_pc, exp_npc);
`ifdef IFETCH_ALIGN_CHK_EN
    chk("misaligned", o_misaligned, rd && (rd_pc[1:0] != 2'b00));
`endif

    @(posedge i_clk);
    #1;
    if (outstanding && !rsp) lat_cnt--;
    if (rd) begin
      outq.delete();
      if (rsp) begin
        outstanding = 0;
        killed      = 0;
      end else if (outstanding) begin
        killed = 1;
      end
    end else begin
      if (consume) void'(outq.pop_front());
      if (rsp) begin
        outstanding = 0;
        if (!killed) outq.push_back('{pend_addr, rdata});
        killed = 0;
      end
    end
    if (hs) begin
      outstanding = 1;
      pend_addr   = pc_m;
      lat_cnt     = lat_rand ? int'($urandom_range(1, 3)) : lat_cfg;
    end
    if (exp_pw) pc_m = exp_npc;
    first = 0;
  endtask

  // Reset the DUT and the bench's memory/PC together, checking reset values while held.
  task automatic do_reset(input int n);
    i_rst            = 1'b1;
    i_redirect       = 1'b0;
    i_redirect_pc    = 32'd0;
    i_imem_req_ready = 1'b1;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = 32'd0;
    i_id_ready       = 1'b1;
    i_pc             = 32'd0;
    @(posedge i_clk);
    #1;
    repeat (n) begin
      @(negedge i_clk);
      chk("rst_if_valid", o_if_valid, 1'b0);
      chk("rst_if_pc", o_if_pc, 32'd0);
      chk("rst_if_instr", o_if_instr, NOP);
      chk("rst_pc_write", o_pc_write, 1'b0);
      chk("rst_req_valid", o_imem_req_valid, 1'b0);
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b0;
    outq.delete();
    outstanding = 0;
    killed      = 0;
    first       = 1;
    pc_m        = 32'd0;
  endtask

  task automatic rand_step();
    step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
  endtask

  initial begin
    salt     = $urandom;
    lat_cfg  = 1;
    lat_rand = 0;
    i_rst    = 1'b1;
    do_reset(2);

    // Zero-wait stream: requests 0,4,8,... one instruction every two cycles.
    repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Decode stalls: output holds, second fetch goes to the skid buffer, requests stop.
    repeat (6) step(1'b0, 32'd0, 1'b1, 1'b0);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Redirect while waiting on a slow response: that response must be dropped.
    lat_cfg = 3;
    for (int i = 0; i < 10 && !outstanding; i++) step(1'b0, 32'd0, 1'b1, 1'b1);
    chk("reached_wait", outstanding, 1'b1);
    step(1'b1, 32'h100, 1'b1, 1'b1);
    repeat (8) step(1'b0, 32'd0, 1'b1, 1'b1);
    lat_cfg = 1;

    // Memory not ready for 3 cycles, then a redirect during the stall.
    repeat (3) step(1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h200, 1'b0, 1'b1);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b1);

    // PC wraps from the top of the address space.
    step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    repeat (6) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Misaligned redirect target.
    step(1'b1, 32'h102, 1'b1, 1'b1);
    repeat (4) step(1'b0, 32'd0, 1'b1, 1'b1);

    // Random traffic with variable memory latency.
    lat_rand = 1;
    repeat (600) rand_step();

    // Reset in the middle of an outstanding request, then more random traffic.
    for (int i = 0; i < 50 && !outstanding; i++) rand_step();
    do_reset(2);
    repeat (300) rand_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, SHALL be the value driven on o_if_instr whenever o_if_valid=0.
REQ-002 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst  in  1  reset, synchronous and active-high.
REQ-004 i_pc  in  32  current PC from the PC register.
REQ-005 o_pc_write  out  1  PC register write enable.
REQ-006 o_next_pc  out  32  value the PC register loads when o_pc_write=1.
REQ-007 i_redirect  in  1  / i_redirect_pc  in  32  branch/jump redirect from execute and its target.
REQ-008 o_imem_req_valid  out  1  / i_imem_req_ready  in  1  / o_imem_req_addr  out  32  instruction memory request channel.
REQ-009 i_imem_rsp_valid  in  1  / i_imem_rsp_data  in  32  response channel, no backpressure, at most one outstanding request.
REQ-010 o_if_valid  out  1  / o_if_pc  out  32  / o_if_instr  out  32  / i_id_ready  in  1  registered IF/ID output with valid/ready handshake.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DROP; IDLE -> REQ unconditionally on the first cycle after reset.
REQ-012 o_imem_req_valid SHALL be (state==REQ && !i_redirect); o_imem_req_addr SHALL equal i_pc.
REQ-013 Request handshake (valid && ready): o_pc_write=1, o_next_pc=i_pc+4 (mod 2^32, wraps at 32'hFFFFFFFC to 0), request PC latched, -> WAIT.
REQ-014 In REQ without ready, i_pc and the request address SHALL stay stable; PC is not written.
REQ-015 WAIT with i_imem_rsp_valid: if output slot free (o_if_valid=0 or i_id_ready=1), load {latched PC, data} into output, o_if_valid=1, -> REQ; otherwise store them in the one-entry skid buffer, -> HOLD.
REQ-016 HOLD: on i_id_ready, skid buffer moves to output (o_if_valid stays 1), -> REQ; no request is issued in HOLD.
REQ-017 Output handshake: o_if_valid falls on (o_if_valid && i_id_ready) unless new data loads in the same cycle; output fields are held stable while o_if_valid && !i_id_ready.
REQ-018 i_redirect=1 in any state SHALL force o_pc_write=1, o_next_pc=i_redirect_pc (priority over +4), clear o_if_valid and skid buffer the next cycle.
REQ-019 Redirect next-state: IDLE/REQ/HOLD -> REQ; WAIT -> DROP; DROP stays DROP; if i_imem_rsp_valid occurs in that same cycle from WAIT or DROP, the response is discarded and next state is REQ.
REQ-020 DROP: the next response SHALL be discarded (never reaches output), then -> REQ.
REQ-021 Fetch-to-output latency SHALL be 1 cycle after i_imem_rsp_valid when the slot is free; zero-wait memory yields one instruction per 2 cycles.

Reset
REQ-022 While i_rst=1: state=IDLE, o_if_valid=0, o_if_pc=0, o_if_instr=NOP_INSTR, o_pc_write=0, o_imem_req_valid=0, skid buffer empty; reset mid-transaction SHALL abandon it, and the bench SHALL reset memory alongside.

Configuration
REQ-023 With IFETCH_ALIGN_CHK_EN defined: output o_misaligned (1 bit) SHALL pulse high for the redirect cycle when i_redirect_pc[1:0]!=0, and o_next_pc SHALL be {i_redirect_pc[31:2],2'b00}.
REQ-024 Without IFETCH_ALIGN_CHK_EN: port o_misaligned is absent and i_redirect_pc is passed through verbatim.

Verification
REQ-025 Reset release, i_pc=0, memory ready always, 1-cycle response -> requests at 0,4,8; o_if_pc=0/4/8 with matching data; o_next_pc=4/8/12.
REQ-026 i_id_ready=0 after first instruction, second response arrives -> state HOLD, o_if_pc stays 0; raise ready -> o_if_pc=4 next cycle, no request while in HOLD.
REQ-027 Redirect to 32'h100 while in WAIT for PC 8 -> response for 8 discarded, next request addr 32'h100, o_if_valid=0 meanwhile.
REQ-028 i_imem_req_ready low 3 cycles -> o_imem_req_addr constant, o_pc_write=0 for those cycles; redirect during the stall -> no handshake that cycle, PC loads target.
REQ-029 i_pc=32'hFFFFFFFC handshake -> o_next_pc=0.
REQ-030 With IFETCH_ALIGN_CHK_EN, redirect to 32'h102 -> o_misaligned=1 one cycle, o_next_pc=32'h100; without it, o_next_pc=32'h102.
